// File: rtl/i2c_cmd_seq_pkg.sv
// i2c_cmd_seq_pkg: shared states, i2c_core register map and status bit positions
package i2c_cmd_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_LL, S_HDR_LH, S_DRAIN, S_CFG, S_LOAD, S_KICK,
    S_GAP, S_POLL, S_PWAIT, S_UNLOAD, S_UWAIT, S_URSP, S_STATUS
  } state_e;
  localparam int REG_RST    = 0;
  localparam int REG_START  = 1;
  localparam int REG_ADDR   = 2;
  localparam int REG_SIZE_L = 3;
  localparam int REG_SIZE_H = 4;
  localparam int MEM_OFFSET = 8;
  localparam int ST_DONE    = 0;
  localparam int ST_NO_ACK  = 1;
  localparam int ST_LEN_ERR = 2;
  localparam int ST_TIMEOUT = 3;
endpackage

// File: rtl/i2c_cmd_seq_busif.sv
// i2c_cmd_seq_busif: registered one-cycle bus strobes and read-capture pipeline
module i2c_cmd_seq_busif #(
  parameter int ABUSWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_rd,
  input  logic                 req_wr,
  input  logic [ABUSWIDTH-1:0] req_addr,
  input  logic [7:0]           req_data,
  output logic                 rd_ack,
  output logic [7:0]           rd_data,
  output logic [ABUSWIDTH-1:0] m_add,
  output logic [7:0]           m_data_o,
  input  logic [7:0]           m_data_i,
  output logic                 m_rd,
  output logic                 m_wr
);
  logic [ABUSWIDTH-1:0] add_q, add_d;
  logic [7:0]           dat_q, dat_d;
  logic                 rd_q, rd_d, wr_q, wr_d, rdp_q, rdp_d;
  // a request becomes a strobe next cycle; rdp marks the cycle the core returns read data
  always_comb begin
    add_d = (req_rd || req_wr) ? req_addr : add_q;
    dat_d = req_wr ? req_data : dat_q;
    rd_d  = req_rd;
    wr_d  = req_wr && !req_rd;
    rdp_d = rd_q;
  end
  // strobe and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q <= '0;
      dat_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      rdp_q <= 1'b0;
    end else begin
      add_q <= add_d;
      dat_q <= dat_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      rdp_q <= rdp_d;
    end
  end
  assign m_add    = add_q;
  assign m_data_o = dat_q;
  assign m_rd     = rd_q;
  assign m_wr     = wr_q;
  assign rd_ack   = rdp_q;
  assign rd_data  = m_data_i;
endmodule

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: byte-stream command sequencer mastering an i2c_core register/memory map
module i2c_cmd_seq
  import i2c_cmd_seq_pkg::*;
#(
  parameter int ABUSWIDTH = 16,
  parameter int BASEADDR  = 0,
  parameter int MEM_BYTES = 16,
  parameter int POLL_GAP  = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [7:0]           CMD_DATA,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  output logic [7:0]           RSP_DATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [ABUSWIDTH-1:0] M_ADD,
  output logic [7:0]           M_DATA_O,
  input  logic [7:0]           M_DATA_I,
  output logic                 M_RD,
  output logic                 M_WR,
  output logic                 BUSY
);
  localparam logic [ABUSWIDTH-1:0] BASE = ABUSWIDTH'(BASEADDR);
  state_e               state_q, state_d;
  logic                 rw_q, rw_d, no_ack_q, no_ack_d, len_err_q, len_err_d, tout_q, tout_d;
  logic                 rsp_valid_q, rsp_valid_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic [7:0]           addr_q, addr_d, rsp_data_q, rsp_data_d, req_data, rd_data, st;
  logic [15:0]          len_q, len_d, idx_q, idx_d, gap_q, gap_d, poll_q, poll_d, hdr_len;
  logic                 req_rd, req_wr, rd_ack, acc, last;
  logic [ABUSWIDTH-1:0] req_addr, mem_addr;
  assign acc      = CMD_VALID && cmd_ready_q;
  assign hdr_len  = {CMD_DATA, len_q[7:0]};
  assign last     = idx_q == len_q - 16'd1;
  assign mem_addr = BASE + ABUSWIDTH'(MEM_OFFSET) + ABUSWIDTH'(idx_q);
  // next-state, bus requests and registered-output next values
  always_comb begin
    state_d = state_q; rw_d = rw_q; addr_d = addr_q; len_d = len_q; idx_d = idx_q;
    gap_d = gap_q; poll_d = poll_q; no_ack_d = no_ack_q; len_err_d = len_err_q; tout_d = tout_q;
    rsp_data_d = rsp_data_q; rsp_valid_d = rsp_valid_q;
    req_rd = 1'b0; req_wr = 1'b0; req_addr = BASE; req_data = '0;
    st = '0; st[ST_DONE] = 1'b1; st[ST_NO_ACK] = no_ack_q; st[ST_LEN_ERR] = len_err_q; st[ST_TIMEOUT] = tout_q;
    case (state_q)
      S_IDLE: if (acc) begin addr_d = CMD_DATA; rw_d = CMD_DATA[0]; state_d = S_HDR_LL; end
      S_HDR_LL: if (acc) begin len_d[7:0] = CMD_DATA; state_d = S_HDR_LH; end
      S_HDR_LH: if (acc) begin
        len_d = hdr_len; idx_d = '0;
        if (hdr_len == 16'd0 || int'(hdr_len) > MEM_BYTES) begin
          len_err_d = 1'b1;
          state_d = (rw_q || hdr_len == 16'd0) ? S_STATUS : S_DRAIN;
        end else state_d = S_CFG;
      end
      S_DRAIN: if (acc) begin idx_d = idx_q + 16'd1; if (last) state_d = S_STATUS; end
      S_CFG: begin
        req_wr = 1'b1;
        req_addr = BASE + ABUSWIDTH'(idx_q == 16'd0 ? REG_ADDR : idx_q == 16'd1 ? REG_SIZE_L : REG_SIZE_H);
        req_data = idx_q == 16'd0 ? addr_q : idx_q == 16'd1 ? len_q[7:0] : len_q[15:8];
        idx_d = idx_q == 16'd2 ? 16'd0 : idx_q + 16'd1;
        if (idx_q == 16'd2) state_d = rw_q ? S_KICK : S_LOAD;
      end
      S_LOAD: if (acc) begin
        req_wr = 1'b1; req_addr = mem_addr; req_data = CMD_DATA; idx_d = idx_q + 16'd1;
        if (last) state_d = S_KICK;
      end
      S_KICK: begin
        req_wr = 1'b1; req_addr = BASE + ABUSWIDTH'(REG_START);
        poll_d = '0; gap_d = '0; state_d = S_GAP;
      end
      S_GAP: begin gap_d = gap_q + 16'd1; if (gap_q == 16'(POLL_GAP - 1)) state_d = S_POLL; end
      S_POLL: begin
        req_rd = 1'b1; req_addr = BASE + ABUSWIDTH'(REG_START);
        poll_d = poll_q + 16'd1; state_d = S_PWAIT;
      end
      S_PWAIT: if (rd_ack) begin
        if (rd_data[ST_DONE]) begin
          no_ack_d = rd_data[ST_NO_ACK]; idx_d = '0; state_d = rw_q ? S_UNLOAD : S_STATUS;
        end else if (poll_q == 16'(TIMEOUT)) begin
          tout_d = 1'b1; req_wr = 1'b1; req_addr = BASE + ABUSWIDTH'(REG_RST); state_d = S_STATUS;
        end else begin gap_d = '0; state_d = S_GAP; end
      end
      S_UNLOAD: begin req_rd = 1'b1; req_addr = mem_addr; state_d = S_UWAIT; end
      S_UWAIT: if (rd_ack) begin rsp_data_d = rd_data; rsp_valid_d = 1'b1; state_d = S_URSP; end
      S_URSP: if (RSP_READY) begin
        rsp_valid_d = 1'b0; idx_d = idx_q + 16'd1; state_d = last ? S_STATUS : S_UNLOAD;
      end
      S_STATUS: if (!rsp_valid_q) begin
        rsp_valid_d = 1'b1; rsp_data_d = st;
      end else if (RSP_READY) begin
        rsp_valid_d = 1'b0; no_ack_d = 1'b0; len_err_d = 1'b0; tout_d = 1'b0; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = state_d inside {S_IDLE, S_HDR_LL, S_HDR_LH, S_DRAIN} ||
                  (state_d == S_LOAD && !(state_q == S_LOAD && acc));
    busy_d = state_d != S_IDLE;
  end
  // state and registered outputs
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= S_IDLE; rw_q <= 1'b0; addr_q <= '0; len_q <= '0; idx_q <= '0;
      gap_q <= '0; poll_q <= '0; no_ack_q <= 1'b0; len_err_q <= 1'b0; tout_q <= 1'b0;
      rsp_data_q <= '0; rsp_valid_q <= 1'b0; cmd_ready_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d; rw_q <= rw_d; addr_q <= addr_d; len_q <= len_d; idx_q <= idx_d;
      gap_q <= gap_d; poll_q <= poll_d; no_ack_q <= no_ack_d; len_err_q <= len_err_d; tout_q <= tout_d;
      rsp_data_q <= rsp_data_d; rsp_valid_q <= rsp_valid_d; cmd_ready_q <= cmd_ready_d; busy_q <= busy_d;
    end
  end
  i2c_cmd_seq_busif #(.ABUSWIDTH(ABUSWIDTH)) u_busif (
    .clk(BUS_CLK), .rst_n(BUS_RST_N), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_data(req_data), .rd_ack(rd_ack), .rd_data(rd_data), .m_add(M_ADD), .m_data_o(M_DATA_O),
    .m_data_i(M_DATA_I), .m_rd(M_RD), .m_wr(M_WR)
  );
  assign CMD_READY = cmd_ready_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VALID = rsp_valid_q;
  assign BUSY      = busy_q;
endmodule
